// File: rtl/imul_seq_ctrl_pkg.sv
// -----------------------------------------------------------------------------
// imul_seq_ctrl_pkg
// Shared definitions for the sequential shift-add multiplier controller:
//   - IMUL_NB_DEFAULT : default operand width
//   - imul_state_e    : FSM state encodings (IDLE=0, RUN=1, DONE=2)
//   - imul_cnt_width  : step-counter width, clog2(nb)+1
//   - IMUL_CW_DEFAULT : counter width for the default operand width
// No ports (package).
// -----------------------------------------------------------------------------
package imul_seq_ctrl_pkg;

   localparam int IMUL_NB_DEFAULT = 16;

   typedef enum logic [1:0] {
      IMUL_ST_IDLE = 2'd0,
      IMUL_ST_RUN  = 2'd1,
      IMUL_ST_DONE = 2'd2
   } imul_state_e;

   // One extra bit so the counter can hold the value NB itself.
   function automatic int imul_cnt_width(input int nb);
      return $clog2(nb) + 1;
   endfunction

   localparam int IMUL_CW_DEFAULT = imul_cnt_width(IMUL_NB_DEFAULT);

endpackage : imul_seq_ctrl_pkg

// File: rtl/imul_seq_ctrl_row_adder.sv
// -----------------------------------------------------------------------------
// full_adder / imul_row_adder
// Single shared row adder used by imul_seq_ctrl to accumulate one partial
// product row per cycle. Plain ripple-carry chain of full_adder cells.
//
// full_adder ports:
//   a_i, b_i, c_i : input bits and carry-in
//   s_o, c_o      : sum bit and carry-out
//
// imul_row_adder (parameter W) ports:
//   A   [W-1:0] : first addend
//   B   [W-1:0] : second addend
//   Sum [W-1:0] : A + B, truncated to W bits
//   Co          : carry-out of the top bit
// -----------------------------------------------------------------------------
module full_adder (
   input  logic a_i,
   input  logic b_i,
   input  logic c_i,
   output logic s_o,
   output logic c_o
);

   assign s_o = a_i ^ b_i ^ c_i;
   assign c_o = (a_i & b_i) | (c_i & (a_i ^ b_i));

endmodule : full_adder

module imul_row_adder #(
   parameter int W = 32
) (
   input  logic [W-1:0] A,
   input  logic [W-1:0] B,
   output logic [W-1:0] Sum,
   output logic         Co
);

   logic [W:0] carry;

   assign carry[0] = 1'b0;

   for (genvar i = 0; i < W; i++) begin : g_fa
      full_adder u_fa (
         .a_i (A[i]),
         .b_i (B[i]),
         .c_i (carry[i]),
         .s_o (Sum[i]),
         .c_o (carry[i+1])
      );
   end

   assign Co = carry[W];

endmodule : imul_row_adder

// File: rtl/imul_seq_ctrl.sv
// -----------------------------------------------------------------------------
// imul_seq_ctrl
// Sequential shift-add controller for unsigned NB x NB multiplication. One
// partial-product row is added per RUN cycle through a single shared row
// adder; the product is presented on oResult together with a one-cycle oDone.
//
// Parameters:
//   NB : operand width (default 16); product width is 2*NB.
//
// Ports:
//   Clock   in  1     rising-edge clock
//   Reset   in  1     synchronous, active-high reset
//   iStart  in  1     start request, accepted only while oReady=1
//   iA      in  NB    multiplicand, sampled on the accepting edge
//   iB      in  NB    multiplier, sampled on the accepting edge
//   oReady  out 1     high in IDLE only
//   oBusy   out 1     high in RUN and DONE
//   oDone   out 1     one-cycle pulse, oResult valid
//   oResult out 2*NB  product, held until the next DONE
//
// Configuration macro:
//   IMUL_SEQ_EARLY_EXIT_EN : when defined, RUN ends as soon as no multiplier
//                            bits remain (R==0); otherwise RUN is always NB
//                            cycles and the R==0 test does not exist.
// -----------------------------------------------------------------------------
module imul_seq_ctrl
   import imul_seq_ctrl_pkg::*;
#(
   parameter int NB = IMUL_NB_DEFAULT
) (
   input  logic            Clock,
   input  logic            Reset,
   input  logic            iStart,
   input  logic [NB-1:0]   iA,
   input  logic [NB-1:0]   iB,
   output logic            oReady,
   output logic            oBusy,
   output logic            oDone,
   output logic [2*NB-1:0] oResult
);

   localparam int              PW   = 2 * NB;
   localparam int              CW   = imul_cnt_width(NB);
   localparam logic [CW-1:0]   LAST = CW'(NB);

   imul_state_e   state_q,  state_d;
   logic [PW-1:0] m_q,      m_d;       // multiplicand, shifted left per step
   logic [PW-1:0] p_q,      p_d;       // running partial product
   logic [NB-1:0] r_q,      r_d;       // remaining multiplier bits
   logic [CW-1:0] cnt_q,    cnt_d;     // completed RUN steps
   logic [PW-1:0] result_q, result_d;

   logic [PW-1:0] add_sum;
   logic          add_co_unused;       // unsigned NB x NB never exceeds 2*NB bits
   logic          exit_now;

   imul_row_adder #(
      .W (PW)
   ) u_row_adder (
      .A   (p_q),
      .B   (m_q),
      .Sum (add_sum),
      .Co  (add_co_unused)
   );

`ifdef IMUL_SEQ_EARLY_EXIT_EN
   // No multiplier bits left: every further row would add zero.
   assign exit_now = (r_q == '0);
`else
   assign exit_now = 1'b0;
`endif

   // NOTE: every signal driven here gets a default before the case statement,
   // so no path leaves a value unassigned and no latch is inferred.
   always_comb begin
      state_d  = state_q;
      m_d      = m_q;
      p_d      = p_q;
      r_d      = r_q;
      cnt_d    = cnt_q;
      result_d = result_q;
      oReady   = 1'b0;
      oBusy    = 1'b0;
      oDone    = 1'b0;

      case (state_q)
         IMUL_ST_IDLE: begin
            oReady = 1'b1;
            if (iStart) begin
               m_d     = {{NB{1'b0}}, iA};
               r_d     = iB;
               p_d     = '0;
               cnt_d   = '0;
               state_d = IMUL_ST_RUN;
            end
         end

         IMUL_ST_RUN: begin
            oBusy = 1'b1;
            if (exit_now) begin
               state_d  = IMUL_ST_DONE;
               result_d = p_q;
            end else begin
               if (r_q[0]) begin
                  p_d = add_sum;
               end
               m_d   = m_q << 1;
               r_d   = r_q >> 1;
               cnt_d = cnt_q + 1'b1;
               // Result is taken from the freshly computed P, not the old one.
               if (cnt_d == LAST) begin
                  state_d  = IMUL_ST_DONE;
                  result_d = p_d;
               end
            end
         end

         IMUL_ST_DONE: begin
            oBusy   = 1'b1;
            oDone   = 1'b1;
            state_d = IMUL_ST_IDLE;
         end

         default: begin
            state_d = IMUL_ST_IDLE;
         end
      endcase
   end

   // NOTE: state registers use non-blocking assignments so every register
   // samples the pre-edge values computed above, independent of statement order.
   // NOTE: the datapath registers are cleared on reset as well as the state, so
   // an aborted operation leaves nothing behind and oResult reads zero.
   always_ff @(posedge Clock) begin
      if (Reset) begin
         state_q  <= IMUL_ST_IDLE;
         m_q      <= '0;
         p_q      <= '0;
         r_q      <= '0;
         cnt_q    <= '0;
         result_q <= '0;
      end else begin
         state_q  <= state_d;
         m_q      <= m_d;
         p_q      <= p_d;
         r_q      <= r_d;
         cnt_q    <= cnt_d;
         result_q <= result_d;
      end
   end

   assign oResult = result_q;

endmodule : imul_seq_ctrl

// File: tb/tb_imul_seq_ctrl.sv
// -----------------------------------------------------------------------------
// tb_imul_seq_ctrl
// Directed testbench for imul_seq_ctrl (NB=16). Stimulus pushes the expected
// product and RUN-cycle count into a scoreboard queue; an independent monitor
// pops and compares whenever oDone is presented. Expected RUN-cycle counts
// follow IMUL_SEQ_EARLY_EXIT_EN when the bench is built with it.
// -----------------------------------------------------------------------------
module tb_imul_seq_ctrl;

   localparam int NB = 16;
   localparam int PW = 2 * NB;

   logic          Clock = 1'b0;
   logic          Reset;
   logic          iStart;
   logic [NB-1:0] iA;
   logic [NB-1:0] iB;
   logic          oReady;
   logic          oBusy;
   logic          oDone;
   logic [PW-1:0] oResult;

   int n_checks = 0;
   int n_pass   = 0;

   typedef struct {
      logic [PW-1:0] res;
      int            cyc;
      string         name;
   } exp_t;

   exp_t sb_q[$];

   always #5 Clock = ~Clock;

   imul_seq_ctrl #(
      .NB (NB)
   ) dut (
      .Clock   (Clock),
      .Reset   (Reset),
      .iStart  (iStart),
      .iA      (iA),
      .iB      (iB),
      .oReady  (oReady),
      .oBusy   (oBusy),
      .oDone   (oDone),
      .oResult (oResult)
   );

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_checks++;
      if (act === exp) n_pass++;
      else $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
   endtask

   // RUN cycles for a vector: hand-derived early-exit count, or NB for a full run.
   function automatic int exp_cycles(input int early);
`ifdef IMUL_SEQ_EARLY_EXIT_EN
      return early;
`else
      return (early > 0) ? NB : NB;
`endif
   endfunction

   task automatic tick();
      @(posedge Clock);
      #1;
   endtask

   task automatic wait_ready(input string name);
      int n = 0;
      while (oReady !== 1'b1 && n < 200) begin
         tick();
         n++;
      end
      check({name, "_ready_wait"}, oReady, 1);
   endtask

   task automatic start_op(input logic [NB-1:0] a, input logic [NB-1:0] b,
                           input logic [PW-1:0] res, input int early,
                           input string name, input bit push);
      wait_ready(name);
      iA     = a;
      iB     = b;
      iStart = 1'b1;
      if (push) sb_q.push_back('{res, exp_cycles(early), name});
      tick();
      iStart = 1'b0;
   endtask

   task automatic run_op(input logic [NB-1:0] a, input logic [NB-1:0] b,
                         input logic [PW-1:0] res, input int early, input string name);
      start_op(a, b, res, early, name, 1'b1);
      wait_ready(name);
   endtask

   // Monitor: counts RUN cycles and checks each oDone against the scoreboard.
   initial begin : monitor
      int   run_cnt   = 0;
      bit   done_prev = 1'b0;
      exp_t e;
      forever begin
         @(negedge Clock);
         if (done_prev) begin
            check("done_width", oDone, 0);
            done_prev = 1'b0;
         end
         if (oDone === 1'b1) begin
            done_prev = 1'b1;
            if (sb_q.size() == 0) begin
               n_checks++;
               $display("FAIL unexpected_done: oDone with oResult=0x%0h, expected no result", oResult);
            end else begin
               e = sb_q.pop_front();
               check({e.name, "_result"}, oResult, e.res);
               check({e.name, "_runcyc"}, run_cnt, e.cyc);
               check({e.name, "_done_ready"}, oReady, 0);
               check({e.name, "_done_busy"}, oBusy, 1);
            end
            run_cnt = 0;
         end else if (oReady === 1'b1 || Reset === 1'b1) begin
            run_cnt = 0;
         end else if (oBusy === 1'b1) begin
            run_cnt++;
         end
      end
   end

   initial begin : stimulus
      int n;
      Reset  = 1'b1;
      iStart = 1'b0;
      iA     = '0;
      iB     = '0;
      tick();
      tick();
      check("por_ready",  oReady,  1);
      check("por_busy",   oBusy,   0);
      check("por_done",   oDone,   0);
      check("por_result", oResult, 0);
      Reset = 1'b0;

      // Basic and extreme operands (early-exit RUN counts hand-derived).
      run_op(16'h0003, 16'h0005, 32'h0000000F, 4,  "basic");
      run_op(16'hFFFF, 16'hFFFF, 32'hFFFE0001, 16, "ones");
      run_op(16'h0000, 16'hBEEF, 32'h00000000, 16, "zero_a");
      run_op(16'h8000, 16'h8000, 32'h40000000, 16, "msb");

      // Reset in the middle of RUN aborts the operation and clears oResult.
      start_op(16'h1234, 16'h5678, '0, 16, "abort", 1'b0);
      repeat (5) tick();
      check("abort_busy_before", oBusy, 1);
      Reset = 1'b1;
      tick();
      Reset = 1'b0;
      check("rst_ready",  oReady,  1);
      check("rst_busy",   oBusy,   0);
      check("rst_done",   oDone,   0);
      check("rst_result", oResult, 0);
      repeat (20) tick();

      // Handshake: starts during RUN and DONE are ignored; start right after DONE works.
      start_op(16'h0011, 16'h0022, 32'h00000242, 7, "hs_first", 1'b1);
      repeat (3) tick();
      iA = 16'hFFFF;
      iB = 16'hFFFF;
      iStart = 1'b1;
      tick();
      iStart = 1'b0;
      n = 0;
      while (oDone !== 1'b1 && n < 200) begin
         tick();
         n++;
      end
      check("hs_done_seen", oDone, 1);
      iA = 16'h7777;
      iB = 16'h7777;
      iStart = 1'b1;
      tick();                              // DONE -> IDLE edge, start ignored
      check("hs_idle_after_done", oReady, 1);
      iA = 16'h0002;
      iB = 16'h0003;
      sb_q.push_back('{32'h00000006, exp_cycles(3), "hs_next"});
      tick();                              // accepted in IDLE
      iStart = 1'b0;
      check("hs_next_accepted", oBusy, 1);
      wait_ready("hs_next");

      // Hold: operand changes without iStart leave oResult untouched.
      for (int i = 0; i < 40; i++) begin
         iA = 16'(i * 16'h1111 + 7);
         iB = 16'(16'hA5A5 ^ (i * 3));
         tick();
      end
      check("hold_result", oResult, 32'h00000006);
      check("hold_ready",  oReady,  1);

      // Early-exit vectors (full NB cycles when the feature is not built in).
      run_op(16'h0101, 16'h0003, 32'h00000303, 3,  "ee_b3");
      run_op(16'h1234, 16'h0000, 32'h00000000, 1,  "ee_b0");
      run_op(16'h0003, 16'h8000, 32'h00018000, 16, "ee_b8000");

      n = 0;
      while (sb_q.size() != 0 && n < 200) begin
         tick();
         n++;
      end
      repeat (3) tick();
      check("sb_empty", sb_q.size(), 0);

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule : tb_imul_seq_ctrl
